// File: rtl/r_rob_pkg.sv
// r_rob_pkg: shared constants and slot/beat types for the R-channel reorder buffer
package r_rob_pkg;
  localparam int ID_W = 4;
  localparam int DATA_W = 64;
  localparam int RESP_W = 2;
  localparam int TAG_W = 4;
  localparam int BEATS = 8;
  localparam int CNT_W = $clog2(BEATS) + 1;
  localparam logic [RESP_W-1:0] RESP_OKAY = 2'b00;
  localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;
  typedef struct packed {
    logic alloc;
    logic done;
    logic ovf;
    logic [ID_W-1:0] id;
    logic [CNT_W-1:0] wcnt;
  } meta_t;
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [RESP_W-1:0] resp;
  } beat_t;
endpackage

// File: rtl/r_rob_slot_mem.sv
// r_rob_slot_mem: per-tag beat storage, one write and one asynchronous read port
module r_rob_slot_mem #(
  parameter int SLOTS = 16,
  parameter int BEATS = 8,
  parameter int W = 66
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(SLOTS)-1:0] wslot,
  input  logic [$clog2(BEATS)-1:0] widx,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(SLOTS)-1:0] rslot,
  input  logic [$clog2(BEATS)-1:0] ridx,
  output logic [W-1:0]             rdata
);
  logic [W-1:0] mem [SLOTS][BEATS];
  always_ff @(posedge clk)
    if (we) mem[wslot][widx] <= wdata;
  assign rdata = mem[rslot][ridx];
endmodule

// File: rtl/r_reorder_buffer.sv
// r_reorder_buffer: buffers out-of-order R bursts per tag and replays them in allocation order
module r_reorder_buffer
  import r_rob_pkg::*;
#(
  parameter int ID_WIDTH = ID_W,
  parameter int DATA_WIDTH = DATA_W,
  parameter int RESP_WIDTH = RESP_W,
  parameter int TAG_WIDTH = TAG_W,
  parameter int MAX_BEATS = BEATS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alloc_valid,
  input  logic [ID_WIDTH-1:0]   alloc_id,
  output logic                  alloc_ready,
  output logic [TAG_WIDTH-1:0]  alloc_tag,
  input  logic                  in_valid,
  input  logic [ID_WIDTH-1:0]   in_id,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [RESP_WIDTH-1:0] in_resp,
  input  logic                  in_last,
  input  logic [TAG_WIDTH-1:0]  in_tagid,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [ID_WIDTH-1:0]   out_id,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [RESP_WIDTH-1:0] out_resp,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  err_unexpected,
  output logic                  err_overflow
);
  localparam int NT = 2 ** TAG_WIDTH;
  localparam int IW = CNT_W - 1;
  meta_t meta [NT];
  meta_t hm, im;
  beat_t rbeat;
  logic [TAG_WIDTH-1:0] head, tail;
  logic [TAG_WIDTH:0] count;
  logic [CNT_W-1:0] rd_idx;
  logic open, full, wr, last_idx, do_alloc, fire, free;
  logic unused;
  assign unused = ^in_id;
  assign hm = meta[head];
  assign im = meta[in_tagid];
  assign open = in_valid & im.alloc & !im.done;
  assign full = im.wcnt == CNT_W'(MAX_BEATS);
  assign wr = open & !full;
  assign in_ready = 1'b1;
  assign alloc_ready = count != (TAG_WIDTH+1)'(NT);
  assign alloc_tag = tail;
  assign do_alloc = alloc_valid & alloc_ready;
  assign last_idx = rd_idx == hm.wcnt - CNT_W'(1);
  // A full slot without last must wait for the overflow beat before its final beat is shown
  assign out_valid = hm.alloc & (rd_idx < hm.wcnt) & (hm.done | !last_idx | hm.wcnt != CNT_W'(MAX_BEATS));
  assign out_last = hm.done & last_idx;
  assign out_id = hm.id;
  assign out_data = rbeat.data;
  assign out_resp = (out_last & hm.ovf) ? RESP_SLVERR : rbeat.resp;
  assign fire = out_valid & out_ready;
  assign free = fire & out_last;
  r_rob_slot_mem #(.SLOTS(NT), .BEATS(MAX_BEATS), .W($bits(beat_t))) u_mem (
    .clk(clk),
    .we(wr),
    .wslot(in_tagid),
    .widx(im.wcnt[IW-1:0]),
    .wdata({in_data, in_resp}),
    .rslot(head),
    .ridx(rd_idx[IW-1:0]),
    .rdata(rbeat)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      rd_idx <= '0;
      err_unexpected <= 1'b0;
      err_overflow <= 1'b0;
      for (int i = 0; i < NT; i++) meta[i] <= '0;
    end else begin
      err_unexpected <= in_valid & (!im.alloc | im.done);
      err_overflow <= open & full;
      if (open) begin
        meta[in_tagid].done <= full | in_last;
        meta[in_tagid].ovf <= full;
        if (!full) meta[in_tagid].wcnt <= im.wcnt + CNT_W'(1);
      end
      if (do_alloc) begin
        meta[tail] <= '{alloc: 1'b1, done: 1'b0, ovf: 1'b0, id: alloc_id, wcnt: '0};
        tail <= tail + TAG_WIDTH'(1);
      end
      if (fire) begin
        rd_idx <= out_last ? '0 : rd_idx + CNT_W'(1);
        if (out_last) begin
          meta[head].alloc <= 1'b0;
          head <= head + TAG_WIDTH'(1);
        end
      end
      count <= count + (TAG_WIDTH+1)'(do_alloc) - (TAG_WIDTH+1)'(free);
    end
endmodule

// File: tb/tb_r_reorder_buffer.sv
// tb_r_reorder_buffer: directed table, corner-case sequences and a randomized scoreboard run
module tb_r_reorder_buffer;
  logic clk = 1'b0, rst_n = 1'b0;
  logic alloc_valid, alloc_ready, in_valid, in_last, in_ready, out_valid, out_last, out_ready;
  logic err_unexpected, err_overflow;
  logic [3:0] alloc_id, alloc_tag, in_id, in_tagid, out_id;
  logic [63:0] in_data, out_data;
  logic [1:0] in_resp, out_resp;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  r_reorder_buffer dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid(alloc_valid), .alloc_id(alloc_id), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .in_valid(in_valid), .in_id(in_id), .in_data(in_data), .in_resp(in_resp), .in_last(in_last),
    .in_tagid(in_tagid), .in_ready(in_ready),
    .out_valid(out_valid), .out_id(out_id), .out_data(out_data), .out_resp(out_resp),
    .out_last(out_last), .out_ready(out_ready),
    .err_unexpected(err_unexpected), .err_overflow(err_overflow)
  );

  typedef struct {
    logic av; logic [3:0] aid; logic iv; logic [3:0] tag; logic il; logic [15:0] d; logic ordy;
    logic ov; logic [3:0] oid; logic ol; logic [15:0] od; logic ar; logic [3:0] at; logic eu;
  } vec_t;
  vec_t tbl[16];

  function automatic vec_t mk(int av, int aid, int iv, int tag, int il, int d, int ordy,
                              int ov, int oid, int ol, int od, int ar, int at, int eu);
    vec_t r;
    r.av = 1'(av); r.aid = 4'(aid); r.iv = 1'(iv); r.tag = 4'(tag); r.il = 1'(il);
    r.d = 16'(d); r.ordy = 1'(ordy); r.ov = 1'(ov); r.oid = 4'(oid); r.ol = 1'(ol);
    r.od = 16'(od); r.ar = 1'(ar); r.at = 4'(at); r.eu = 1'(eu);
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    alloc_valid = 0; alloc_id = 0; in_valid = 0; in_id = 0; in_tagid = 0;
    in_last = 0; in_data = 0; in_resp = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 0; idle(); out_ready = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic beat(input int tag, input logic [63:0] d, input logic l);
    idle(); in_valid = 1; in_tagid = 4'(tag); in_data = d; in_last = l; in_id = 4'($urandom);
  endtask

  // behavioural reference: allocation-order queue plus a beat list per tag
  int m_tail, m_cnt, m_wcnt[16];
  logic m_alloc[16], m_done[16], exp_eu, exp_eu_n, exp_ar, exp_ov, exp_last;
  logic [3:0] m_id[16];
  logic [65:0] m_q[16][$];
  logic [65:0] e;
  int order_q[$], cand[$];

  initial begin
    int t;
    logic ok;
    do_reset();
    chk("reset", {in_ready, out_valid, alloc_ready, alloc_tag, err_unexpected, err_overflow},
        {1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0});

    tbl[0]  = mk(1,3, 0,0,0,0,     0, 0,0,0,0,     1,1,0);
    tbl[1]  = mk(1,5, 0,0,0,0,     0, 0,0,0,0,     1,2,0);
    tbl[2]  = mk(0,0, 1,0,1,'hA0,  1, 1,3,1,'hA0,  1,2,0);
    tbl[3]  = mk(0,0, 1,1,1,'hA1,  1, 1,5,1,'hA1,  1,2,0);
    tbl[4]  = mk(0,0, 0,0,0,0,     1, 0,0,0,0,     1,2,0);
    tbl[5]  = mk(1,7, 0,0,0,0,     1, 0,0,0,0,     1,3,0);
    tbl[6]  = mk(1,9, 0,0,0,0,     1, 0,0,0,0,     1,4,0);
    tbl[7]  = mk(0,0, 1,3,0,'hB0,  1, 0,0,0,0,     1,4,0);
    tbl[8]  = mk(0,0, 1,3,1,'hB1,  1, 0,0,0,0,     1,4,0);
    tbl[9]  = mk(0,0, 1,2,1,'hC0,  0, 1,7,1,'hC0,  1,4,0);
    tbl[10] = mk(0,0, 0,0,0,0,     0, 1,7,1,'hC0,  1,4,0);
    tbl[11] = mk(0,0, 0,0,0,0,     1, 1,9,0,'hB0,  1,4,0);
    tbl[12] = mk(0,0, 0,0,0,0,     1, 1,9,1,'hB1,  1,4,0);
    tbl[13] = mk(0,0, 0,0,0,0,     1, 0,0,0,0,     1,4,0);
    tbl[14] = mk(0,0, 1,7,1,'hDD,  1, 0,0,0,0,     1,4,1);
    tbl[15] = mk(0,0, 0,0,0,0,     1, 0,0,0,0,     1,4,0);
    foreach (tbl[i]) begin
      idle();
      alloc_valid = tbl[i].av; alloc_id = tbl[i].aid; in_valid = tbl[i].iv; in_tagid = tbl[i].tag;
      in_last = tbl[i].il; in_data = 64'(tbl[i].d); out_ready = tbl[i].ordy;
      cyc();
      chk($sformatf("table[%0d]", i),
          {out_valid, out_valid ? out_id : 4'd0, out_valid & out_last, out_valid ? out_data : 64'd0,
           out_valid ? out_resp : 2'd0, alloc_ready, alloc_tag, err_unexpected, err_overflow},
          {tbl[i].ov, tbl[i].oid, tbl[i].ol, 64'(tbl[i].od), 2'd0, tbl[i].ar, tbl[i].at, tbl[i].eu, 1'b0});
    end

    // full tag space, then drain one slot and wrap
    do_reset();
    for (int i = 0; i < 16; i++) begin
      idle(); alloc_valid = 1; alloc_id = 4'(i); cyc();
    end
    idle(); cyc();
    chk("full_alloc_ready", {alloc_ready, alloc_tag}, {1'b0, 4'd0});
    beat(0, 64'h33, 1); cyc(); idle();
    chk("full_head_beat", {out_valid, out_id, out_last, out_data}, {1'b1, 4'd0, 1'b1, 64'h33});
    out_ready = 1; cyc();
    chk("wrap_alloc", {alloc_ready, alloc_tag, out_valid}, {1'b1, 4'd0, 1'b0});

    // overflow: nine beats without last
    do_reset();
    idle(); alloc_valid = 1; alloc_id = 4'd2; cyc();
    for (int k = 0; k < 9; k++) begin
      beat(0, 64'h100 + 64'(k), 0); cyc();
    end
    idle();
    chk("ovf_pulse", {err_overflow, err_unexpected}, {1'b1, 1'b0});
    cyc();
    chk("ovf_pulse_end", {err_overflow}, {1'b0});
    out_ready = 1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("ovf_beat%0d", k), {out_valid, out_id, out_last, out_resp, out_data},
          {1'b1, 4'd2, k == 7, (k == 7) ? 2'b10 : 2'b00, 64'h100 + 64'(k)});
      cyc();
    end
    chk("ovf_drained", {out_valid, alloc_ready}, {1'b0, 1'b1});

    // asynchronous reset while a beat is held
    do_reset();
    idle(); alloc_valid = 1; alloc_id = 4'd6; cyc();
    beat(0, 64'h66, 1); cyc(); idle();
    chk("pre_reset_valid", {out_valid}, {1'b1});
    #2 rst_n = 0;
    #1 chk("async_reset", {out_valid, alloc_ready, alloc_tag}, {1'b0, 1'b1, 4'd0});
    @(negedge clk); rst_n = 1; out_ready = 1;
    ok = 1;
    repeat (5) begin
      cyc();
      if (out_valid !== 1'b0 || alloc_tag !== 4'd0) ok = 0;
    end
    chk("no_stale_beats", {ok}, {1'b1});

    // randomized traffic against the reference model
    do_reset();
    m_tail = 0; m_cnt = 0; exp_eu = 0; order_q.delete();
    for (int i = 0; i < 16; i++) begin
      m_alloc[i] = 0; m_done[i] = 0; m_wcnt[i] = 0; m_id[i] = 0; m_q[i].delete();
    end
    for (int n = 0; n < 3000; n++) begin
      exp_ar = m_cnt != 16;
      exp_ov = order_q.size() > 0 && m_q[order_q[0]].size() > 0;
      chk("rnd_status", {alloc_ready, alloc_tag, err_unexpected, err_overflow, out_valid},
          {exp_ar, 4'(m_tail), exp_eu, 1'b0, exp_ov});
      idle();
      out_ready = ($urandom % 4) != 0;
      if (out_valid && out_ready && exp_ov) begin
        t = order_q[0];
        e = m_q[t].pop_front();
        exp_last = m_done[t] && m_q[t].size() == 0;
        chk("rnd_beat", {out_id, out_last, out_data, out_resp}, {m_id[t], exp_last, e});
        if (exp_last) begin
          void'(order_q.pop_front());
          m_alloc[t] = 0;
          m_cnt--;
        end
      end
      exp_eu_n = 0;
      cand.delete();
      for (int i = 0; i < 16; i++) if (m_alloc[i] && !m_done[i]) cand.push_back(i);
      t = int'($urandom % 10);
      if (t < 5 && cand.size() > 0) begin
        t = cand[$urandom % cand.size()];
        beat(t, {$urandom, $urandom}, ($urandom % 3 == 0) || m_wcnt[t] == 7);
        in_resp = 2'($urandom);
        m_q[t].push_back({in_data, in_resp});
        m_wcnt[t]++;
        m_done[t] = in_last;
      end else if (t == 5) begin
        t = int'($urandom % 16);
        if (!m_alloc[t] || m_done[t]) begin
          beat(t, {$urandom, $urandom}, 1'($urandom));
          exp_eu_n = 1;
        end
      end
      if ($urandom % 3 == 0) begin
        alloc_valid = 1;
        alloc_id = 4'($urandom);
        if (exp_ar) begin
          m_alloc[m_tail] = 1; m_done[m_tail] = 0; m_wcnt[m_tail] = 0; m_id[m_tail] = alloc_id;
          order_q.push_back(m_tail);
          m_tail = (m_tail + 1) % 16;
          m_cnt++;
        end
      end
      exp_eu = exp_eu_n;
      @(negedge clk);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/r_reorder_buffer.md
Name: r_reorder_buffer

Overview:
- Sits directly downstream of the slave-side AXI read data channel in the ROB path.
- Accepts R beats carrying the internal tagid in any order across tags. Buffers each burst in a per-tag slot.
- Re-emits bursts to the master side strictly in tag-allocation order, with the original ID restored.
- Also owns tag allocation: the AR path requests a tag here before issuing a read.

Parameters:
- ID_WIDTH, 4, AXI transaction ID width.
- DATA_WIDTH, 64, R data width.
- RESP_WIDTH, 2, R response width.
- TAG_WIDTH, 4, internal tag width; NUM_TAGS = 2**TAG_WIDTH slots.
- MAX_BEATS, 8, max beats buffered per tag (power of 2).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- alloc_valid  in  1  AR path requests a tag
- alloc_id  in  ID_WIDTH  original AXI ID to restore on output
- alloc_ready  out  1  tag available
- alloc_tag  out  TAG_WIDTH  tag granted (valid with alloc_ready)
- in_valid  in  1  R beat from slave side
- in_id  in  ID_WIDTH  ignored (stored alloc_id is authoritative)
- in_data  in  DATA_WIDTH  beat data
- in_resp  in  RESP_WIDTH  beat response
- in_last  in  1  last beat of burst
- in_tagid  in  TAG_WIDTH  tag of beat
- in_ready  out  1  beat accepted
- out_valid  out  1  in-order beat to master
- out_id  out  ID_WIDTH  restored ID
- out_data  out  DATA_WIDTH  data
- out_resp  out  RESP_WIDTH  response
- out_last  out  1  last beat
- out_ready  in  1  master accepts
- err_unexpected  out  1  one-cycle pulse: beat to unallocated or already-completed tag, dropped
- err_overflow  out  1  one-cycle pulse: beat beyond MAX_BEATS, dropped

Behaviour:
- Reset state:
  - head = tail = 0, outstanding count = 0.
  - All slot alloc/done flags, write counts and read index = 0.
  - out_valid = 0, err_* = 0, alloc_ready = 1, alloc_tag = 0.
- Allocation:
  - alloc_tag = tail; alloc_ready = (count != NUM_TAGS), from registered count.
  - On alloc_valid & alloc_ready:
    - slot[tail].alloc = 1, id = alloc_id, wcnt = 0, done = 0.
    - tail++ (wraps mod NUM_TAGS), count++.
- Input:
  - in_ready is tied 1 after reset; the block never back-pressures.
  - A beat to a slot with alloc=1, done=0 and wcnt<MAX_BEATS is written at index wcnt; wcnt++; done = in_last.
  - A beat to a slot with alloc=0 or done=1 is dropped and pulses err_unexpected the next cycle.
  - A beat to a slot with wcnt==MAX_BEATS is dropped, pulses err_overflow, and forces done=1 so the slot can drain. The last stored beat then goes out with out_last=1 and out_resp=SLVERR (2'b10).
- Output (cut-through on the head slot):
  - out_valid = slot[head].alloc & (rd_idx < slot[head].wcnt).
  - out_data/out_resp come from slot[head][rd_idx]; out_id = slot[head].id.
  - out_last = done & (rd_idx == wcnt-1).
  - All are registered from storage: a beat accepted in cycle N is visible on out no earlier than cycle N+1.
  - out_valid, once high, holds with stable payload until out_ready.
  - On a non-last handshake: rd_idx++.
  - On a last handshake: slot freed (alloc=0), head++ (wraps), rd_idx = 0, count--.
- Simultaneous events:
  - Allocation and free in the same cycle: count is unchanged. A freed slot cannot be re-granted in the same cycle.
  - A write to the head slot and a read of the head slot in the same cycle: the read uses the pre-write wcnt.
- Reset mid-operation: all buffered beats are discarded immediately and outputs return to reset values asynchronously.

Decomposition:
- Package r_rob_pkg holds:
  - RESP_OKAY/RESP_SLVERR constants.
  - Slot metadata struct (alloc, done, id, wcnt).
  - Beat struct (data, resp).
- One natural sub-module: r_rob_slot_mem, a NUM_TAGS×MAX_BEATS beat storage with 1 write and 1 read port, flop array.

Test Plan:
1. Allocate tags 0,1 (IDs 3,5). Single beat to tag 0, then tag 1 -> out: id 3 then id 5, each with last=1, in order.
2. Allocate 0,1. Beats to tag 1 first (2 beats), then tag 0 (1 beat) -> nothing out until tag 0 arrives; then tag 0 beat, then tag 1's two beats, last only on beat 2.
3. Allocate 16 tags without returning data -> alloc_ready=0. Complete tag 0 and drain it -> alloc_ready=1 next cycle, alloc_tag=0 (wrap).
4. Beat with in_tagid=7 when unallocated -> dropped, err_unexpected pulses one cycle, output unaffected.
5. Send 9 beats with no last to tag 0 (MAX_BEATS=8) -> err_overflow pulse, 8 beats out, beat 8 has last=1 and resp=2'b10.
6. Assert rst_n=0 while out_valid=1 with out_ready=0 -> out_valid=0 immediately. After release, alloc_tag=0 and no stale beats appear.
